i2s_rx: RTL

- Serial PCM receiver: recovers stereo sample pairs from an I2S-style stream (bck, lrck, sdata) and presents them as parallel words.
- Sampling end for the sine-wave PCM generator. Closes the loop in loopback benches and forms the front end of the DSP datapath.
- bck, lrck and sdata are asynchronous to i_clk. They are synchronised and oversampled; i_clk is the only clock.

---
 rtl/pcm_pkg.sv | 16 +
 rtl/shift_register.sv | 24 ++
 rtl/sync_edge.sv | 33 +++
 rtl/i2s_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// rtl/pcm_pkg.sv - shared PCM constants, channel encoding and receiver state encoding
package pcm_pkg;

  localparam int PCM_WIDTH = 24;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    SKIP      = 2'd1,
    SHIFT     = 2'd2,
    HOLD      = 2'd3
  } rx_state_t;

endpackage

// File: rtl/shift_register.sv
// rtl/shift_register.sv - serial-in parallel-out shift register, MSB first, with parallel load
module shift_register #(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sdata,
  input  logic             i_shift,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else if (i_load) begin
      o_data <= i_data;
    end else if (i_shift) begin
      o_data <= {o_data[WIDTH-2:0], i_sdata};
    end
  end

endmodule

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - N-stage input synchroniser with registered rising- and any-edge pulses
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_edge
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // o_q is the delayed copy so level and edge pulses line up on the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chain  <= '0;
      prev   <= 1'b0;
      o_rise <= 1'b0;
      o_edge <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], i_d};
      prev   <= chain[STAGES-1];
      o_rise <= chain[STAGES-1] & ~prev;
      o_edge <= chain[STAGES-1] ^ prev;
    end
  end

  assign o_q = prev;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S / left-justified serial PCM receiver, oversampled on i_clk
module i2s_rx
  import pcm_pkg::*;
#(
  parameter int WIDTH       = PCM_WIDTH,
  parameter int DELAY       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bck,
  input  logic             i_lrck,
  input  logic             i_sdata,
  output logic [WIDTH-1:0] o_left,
  output logic [WIDTH-1:0] o_right,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_locked
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (DELAY > 2) ? $clog2(DELAY - 1) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL      = CW'(WIDTH);
  localparam logic [SW-1:0] SKIP_INIT = SW'((DELAY > 1) ? DELAY - 2 : 0);

  logic             tick;
  logic             bck_s;
  logic             bck_edge;
  logic             lrck_s;
  logic             lrck_rise;
  logic             lrck_edge;
  logic             sdata_s;
  logic [SYNC_STAGES:0] sd_chain;
  logic             unused_sync;

  rx_state_t        state;
  logic [CW-1:0]    bit_ctr;
  logic [SW-1:0]    skip_ctr;
  logic             lrck_last;
  logic             lr_change;
  logic             cur_ch;
  logic             word_done;
  logic             word_ch;
  logic             short_err;
  logic             shift_en;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] left_hold;
  logic             left_ok;

  sync_edge #(.STAGES(SYNC_STAGES)) u_bck_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_bck),
    .o_q     (bck_s),
    .o_rise  (tick),
    .o_edge  (bck_edge)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_lrck_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_lrck),
    .o_q     (lrck_s),
    .o_rise  (lrck_rise),
    .o_edge  (lrck_edge)
  );

  assign unused_sync = ^{bck_s, bck_edge, lrck_rise, lrck_edge};

  // One extra stage keeps sdata aligned with the registered bck tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sd_chain <= '0;
    end else begin
      sd_chain <= {sd_chain[SYNC_STAGES-1:0], i_sdata};
    end
  end

  assign sdata_s   = sd_chain[SYNC_STAGES];
  assign lr_change = tick && (lrck_s != lrck_last);

  // With DELAY=0 the change tick itself carries the MSB of the new word
  assign shift_en = tick && (((state == SHIFT) && !lr_change) || ((DELAY == 0) && lr_change));

  shift_register #(.WIDTH(WIDTH)) u_deser (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sdata (sdata_s),
    .i_shift (shift_en),
    .i_load  (1'b0),
    .i_data  ({WIDTH{1'b0}}),
    .o_data  (sr_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= SYNC_WAIT;
      bit_ctr   <= '0;
      skip_ctr  <= '0;
      lrck_last <= 1'b0;
      cur_ch    <= CH_LEFT;
      word_done <= 1'b0;
      word_ch   <= CH_LEFT;
      short_err <= 1'b0;
      o_locked  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      short_err <= 1'b0;
      if (tick) begin
        lrck_last <= lrck_s;
      end
      if (lr_change) begin
        o_locked  <= 1'b1;
        cur_ch    <= lrck_s;
        short_err <= (state == SKIP) || (state == SHIFT);
        if (DELAY == 0) begin
          state   <= SHIFT;
          bit_ctr <= CW'(1);
        end else if (DELAY == 1) begin
          state   <= SHIFT;
          bit_ctr <= '0;
        end else begin
          state    <= SKIP;
          skip_ctr <= SKIP_INIT;
          bit_ctr  <= '0;
        end
      end else if (tick) begin
        case (state)
          SKIP: begin
            if (skip_ctr == '0) begin
              state <= SHIFT;
            end else begin
              skip_ctr <= skip_ctr - SW'(1);
            end
          end
          SHIFT: begin
            if (bit_ctr == LAST_BIT) begin
              bit_ctr   <= FULL;
              word_done <= 1'b1;
              word_ch   <= cur_ch;
              state     <= HOLD;
            end else begin
              bit_ctr <= bit_ctr + CW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Word is read from the shift register the cycle after its last bit lands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      left_hold   <= '0;
      left_ok     <= 1'b0;
      o_left      <= '0;
      o_right     <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= short_err;
      if (word_done) begin
        if (word_ch == CH_LEFT) begin
          left_hold <= sr_q;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          o_left  <= left_hold;
          o_right <= sr_q;
          o_valid <= 1'b1;
          left_ok <= 1'b0;
        end else begin
          o_frame_err <= 1'b1;
        end
      end
    end
  end

endmodule
